// File: rtl/id_ex_if.sv
// ID/EX pipeline register bundle: the decode-side inputs, the writeback
// bypass port, flush, and the registered EX-stage view with its hazard status.
interface id_ex_if #(
  parameter int XLEN = 64
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic [XLEN-1:0] ReadData1;
  logic [XLEN-1:0] ReadData2;
  logic [7:0]      id_ctrl;
  logic            wb_RegWrite;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush;

  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic [7:0]      ex_ctrl;
  logic            stall;
  logic [15:0]     bubble_count;

  modport master (
    output id_valid, id_pc, id_imm, id_rs1, id_rs2, id_rd,
           ReadData1, ReadData2, id_ctrl,
           wb_RegWrite, wb_rd, wb_data, flush,
    input  ex_valid, ex_pc, ex_a, ex_b, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_ctrl, stall, bubble_count
  );

  modport slave (
    input  id_valid, id_pc, id_imm, id_rs1, id_rs2, id_rd,
           ReadData1, ReadData2, id_ctrl,
           wb_RegWrite, wb_rd, wb_data, flush,
    output ex_valid, ex_pc, ex_a, ex_b, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_ctrl, stall, bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass into the operands, load-use
// hazard detection, flush handling and a saturating count of inserted bubbles.
module id_ex_stage #(
  parameter int XLEN = 64
) (
  input  logic   clk,
  input  logic   reset,
  id_ex_if.slave bus
);

  localparam int MEM_READ_BIT = 6;

  logic            exValid_q,  exValid_d;
  logic [XLEN-1:0] exPc_q,     exPc_d;
  logic [XLEN-1:0] exA_q,      exA_d;
  logic [XLEN-1:0] exB_q,      exB_d;
  logic [XLEN-1:0] exImm_q,    exImm_d;
  logic [4:0]      exRs1_q,    exRs1_d;
  logic [4:0]      exRs2_q,    exRs2_d;
  logic [4:0]      exRd_q,     exRd_d;
  logic [7:0]      exCtrl_q,   exCtrl_d;
  logic [15:0]     bubbleCnt_q, bubbleCnt_d;

  logic hazard;
  logic bubble;

  // x0 reads as zero; a writeback to x0 never bypasses because rs==0 wins first.
  function automatic logic [XLEN-1:0] forwardOperand(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rfData,
    input logic            wbWe,
    input logic [4:0]      wbRd,
    input logic [XLEN-1:0] wbData
  );
    if (rs == 5'd0)
      return '0;
    else if (wbWe && (wbRd == rs))
      return wbData;
    else
      return rfData;
  endfunction

  always_comb begin
    hazard = exValid_q && exCtrl_q[MEM_READ_BIT] && (exRd_q != 5'd0) &&
             bus.id_valid &&
             ((exRd_q == bus.id_rs1) || (exRd_q == bus.id_rs2));
    bubble = bus.flush || hazard;

    exValid_d = bus.id_valid;
    exPc_d    = bus.id_pc;
    exImm_d   = bus.id_imm;
    exRs1_d   = bus.id_rs1;
    exRs2_d   = bus.id_rs2;
    exRd_d    = bus.id_rd;
    exCtrl_d  = bus.id_valid ? bus.id_ctrl : 8'h00;
    exA_d     = forwardOperand(bus.id_rs1, bus.ReadData1,
                               bus.wb_RegWrite, bus.wb_rd, bus.wb_data);
    exB_d     = forwardOperand(bus.id_rs2, bus.ReadData2,
                               bus.wb_RegWrite, bus.wb_rd, bus.wb_data);

    if (bubble) begin
      exValid_d = 1'b0;
      exPc_d    = '0;
      exImm_d   = '0;
      exRs1_d   = 5'd0;
      exRs2_d   = 5'd0;
      exRd_d    = 5'd0;
      exCtrl_d  = 8'h00;
      exA_d     = '0;
      exB_d     = '0;
    end

    // Only bubbles that displace a real decode instruction are counted.
    bubbleCnt_d = bubbleCnt_q;
    if (bubble && bus.id_valid && (bubbleCnt_q != 16'hFFFF))
      bubbleCnt_d = bubbleCnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      exValid_q   <= 1'b0;
      exPc_q      <= '0;
      exA_q       <= '0;
      exB_q       <= '0;
      exImm_q     <= '0;
      exRs1_q     <= 5'd0;
      exRs2_q     <= 5'd0;
      exRd_q      <= 5'd0;
      exCtrl_q    <= 8'h00;
      bubbleCnt_q <= 16'd0;
    end else begin
      exValid_q   <= exValid_d;
      exPc_q      <= exPc_d;
      exA_q       <= exA_d;
      exB_q       <= exB_d;
      exImm_q     <= exImm_d;
      exRs1_q     <= exRs1_d;
      exRs2_q     <= exRs2_d;
      exRd_q      <= exRd_d;
      exCtrl_q    <= exCtrl_d;
      bubbleCnt_q <= bubbleCnt_d;
    end
  end

  assign bus.stall        = hazard && !bus.flush && reset;
  assign bus.ex_valid     = exValid_q;
  assign bus.ex_pc        = exPc_q;
  assign bus.ex_a         = exA_q;
  assign bus.ex_b         = exB_q;
  assign bus.ex_imm       = exImm_q;
  assign bus.ex_rs1       = exRs1_q;
  assign bus.ex_rs2       = exRs2_q;
  assign bus.ex_rd        = exRd_q;
  assign bus.ex_ctrl      = exCtrl_q;
  assign bus.bubble_count = bubbleCnt_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 64, datapath width of operands, PC and immediate.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low; sampled on rising clk edge.
REQ-004 id_valid  input  1  decode stage holds a valid instruction.
REQ-005 id_pc, id_imm  input  XLEN each  decode PC and sign-extended immediate.
REQ-006 id_rs1, id_rs2, id_rd  input  5 each  source/destination register indices.
REQ-007 ReadData1, ReadData2  input  XLEN each  register-file read ports for id_rs1/id_rs2.
REQ-008 id_ctrl  input  8  {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, ALUOp[1:0]}.
REQ-009 wb_RegWrite  input  1; wb_rd  input  5; wb_data  input  XLEN  writeback write port being applied this cycle.
REQ-010 flush  input  1  taken branch/redirect; kill the instruction entering EX.
REQ-011 ex_valid  output  1; ex_pc, ex_a, ex_b, ex_imm  output  XLEN; ex_rs1, ex_rs2, ex_rd  output  5; ex_ctrl  output  8  registered EX-stage fields.
REQ-012 stall  output  1  combinational; upstream holds PC and IF/ID when high.
REQ-013 bubble_count  output  16  registered count of inserted bubbles.

Function
REQ-014 hazard SHALL be ex_valid & ex_ctrl MemRead & (ex_rd != 0) & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2).
REQ-015 stall SHALL equal hazard & ~flush; stall SHALL be 0 while reset is low.
REQ-016 Per-edge priority SHALL be: reset, then flush, then hazard, then normal capture.
REQ-017 Bubble (flush or hazard): ex_valid=0, ex_ctrl=0, all ex data/index fields=0.
REQ-018 Normal capture: all ex_* fields load from id_* in one cycle; ex_valid=id_valid; when id_valid=0, ex_ctrl SHALL load 0.
REQ-019 Operand A SHALL be: 0 if id_rs1==0; else wb_data if wb_RegWrite & wb_rd==id_rs1; else ReadData1.
REQ-020 Operand B SHALL follow REQ-019 with id_rs2/ReadData2.
REQ-021 wb_rd==0 SHALL never bypass, regardless of wb_RegWrite.
REQ-022 Latency from id_* to ex_* SHALL be exactly one cycle; no internal buffering beyond one entry.
REQ-023 A hazard SHALL last exactly one cycle: the following cycle ex_valid=0, so hazard deasserts and the held instruction is captured.
REQ-024 bubble_count SHALL increment by 1 on each edge loading a bubble due to hazard or flush (with id_valid=1), saturating at 16'hFFFF.
REQ-025 Flush coincident with hazard SHALL insert one bubble, stall=0, and increment bubble_count once.

Reset
REQ-026 While reset is low at a rising edge: ex_valid=0, all ex_* fields=0, bubble_count=0.
REQ-027 Reset SHALL override flush, hazard and capture in the same cycle; an in-flight instruction is discarded.
REQ-028 First edge with reset high SHALL perform normal capture per REQ-016.

Verification
REQ-029 Normal: id_valid=1, rs1=5, rs2=6, ReadData1=577, ReadData2=586, ctrl=8'h80 -> next cycle ex_a=577, ex_b=586, ex_valid=1, ex_ctrl=8'h80, stall=0.
REQ-030 WB bypass: wb_RegWrite=1, wb_rd=5, wb_data=64'hDEAD, id_rs1=5, ReadData1=577 -> ex_a=64'hDEAD; repeat with wb_rd=0, id_rs1=0 -> ex_a=0.
REQ-031 Load-use: EX holds MemRead, ex_rd=7; ID rs2=7 -> stall=1, next ex_valid=0, bubble_count=1; following cycle stall=0, instruction captured.
REQ-032 Flush+hazard same cycle -> stall=0, ex_valid=0, ex_ctrl=0, bubble_count +1 only.
REQ-033 Reset low mid-stream with ex_valid=1, bubble_count=3 -> next edge all outputs 0; preload bubble_count=16'hFFFE, two hazards -> holds 16'hFFFF.
